// File: rtl/booth_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier/accumulator.
package booth_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MSUBU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Signed variants sign-extend both operands; codes 6/7 fall back to unsigned.
    function automatic logic is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Accumulating variants start from {HI,LO} instead of zero.
    function automatic logic is_accum(input logic [2:0] op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    // Subtracting variants negate the multiplicand once at load.
    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector: picks 0, +-X or +-2X from a 3-bit group.
module booth_pp_sel #(
    parameter int E = 34
) (
    input  logic [E-1:0] x,
    input  logic [2:0]   grp,
    output logic [E:0]   pp
);

    logic [E:0] x1;
    logic [E:0] x2;

    assign x1 = {x[E-1], x};
    assign x2 = {x, 1'b0};

    // Booth recoding of {b[2i+1], b[2i], b[2i-1]}
    always_comb begin
        pp = '0;
        case (grp)
            3'b001, 3'b010: pp = x1;
            3'b011:         pp = x2;
            3'b100:         pp = '0 - x2;
            3'b101, 3'b110: pp = '0 - x1;
            default:        pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier/accumulator producing a {HI,LO} result.
module booth_mul_iter
    import booth_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic                 flush,
    input  logic                 ack,
    output logic                 ready,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned E   = WIDTH + 2;
    localparam int unsigned N   = E / 2;
    localparam int unsigned PPU = PP_PER_CYCLE;
    localparam int unsigned S   = (N + PPU - 1) / PPU;
    localparam int unsigned AW  = 2 * WIDTH + 4;
    localparam int unsigned SH  = 2 * PPU;
    localparam int unsigned CW  = $clog2(S);
    localparam logic [CW-1:0] LAST = CW'(S - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [E-1:0]  mcand;
    logic [E:0]    mplier;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;
    logic [AW-1:0] term;
    int unsigned   idx;
    logic          accept;
    logic [E-1:0]  a_ext;
    logic [E-1:0]  b_ext;
    logic [E-1:0]  x_load;
    logic [E:0]    pp [PP_PER_CYCLE];

    assign accept = (state == IDLE) && start && !flush;
    assign ready  = (state == IDLE);
    assign busy   = (state == CALC);
    assign valid  = (state == DONE);
    assign result = acc[2*WIDTH-1:0];

    // Operand extension; subtract ops negate the E-bit multiplicand so -2^(WIDTH-1) cannot overflow
    always_comb begin
        a_ext  = is_signed(op) ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        b_ext  = is_signed(op) ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
        x_load = is_sub(op) ? ('0 - a_ext) : a_ext;
    end

    // Low bits of the multiplier shift register form the groups retired this cycle
    for (genvar g = 0; g < PP_PER_CYCLE; g++) begin : g_pp
        booth_pp_sel #(.E(E)) u_sel (
            .x   (mcand),
            .grp (mplier[2*g+2:2*g]),
            .pp  (pp[g])
        );
    end

    // Accumulate this cycle's partial products at their group weights; surplus groups add nothing
    always_comb begin
        acc_next = acc;
        term     = '0;
        idx      = 0;
        for (int unsigned g = 0; g < PPU; g++) begin
            idx  = 32'(cnt) * PPU + g;
            term = {{(AW-E-1){pp[g][E]}}, pp[g]};
            if (idx < N) begin
                acc_next = acc_next + (term << (2 * idx));
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: flush aborts CALC/DONE, ack retires DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = CALC;
            end
            CALC: begin
                if (flush)             state_next = IDLE;
                else if (cnt == LAST)  state_next = DONE;
            end
            DONE: begin
                if (flush || ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand load on accept, one step of accumulation per CALC cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (accept) begin
            cnt    <= '0;
            mcand  <= x_load;
            mplier <= {b_ext, 1'b0};
            acc    <= is_accum(op) ? {4'b0000, acc_in} : '0;
        end else if ((state == CALC) && !flush) begin
            cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
            mplier <= mplier >> SH;
            acc    <= acc_next;
        end
    end

endmodule

// File: doc/booth_mul_iter.md
# booth_mul_iter

Iterative radix-4 Booth multiplier/accumulator for the execute stage. It takes WIDTH-bit operands and handles MULT/MULTU/MADD/MADDU/MSUB/MSUBU. It retires PP_PER_CYCLE Booth partial products per clock and adds them into a 2·WIDTH-bit accumulator that starts from the HI/LO value, so the write-back stage receives the complete {HI,LO} result.

## Interface
- WIDTH, 32: operand width; must be even, ≥ 8.
- PP_PER_CYCLE, 1: Booth partial products summed per cycle; legal values 1 or 2.
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only while ready=1.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU; 6/7 treated as MULTU.
- a  in  WIDTH  multiplicand (rs).
- b  in  WIDTH  multiplier (rt).
- acc_in  in  2·WIDTH  {HI,LO} addend; sampled with start.
- flush  in  1  abort the current operation (exception or branch flush).
- ack  in  1  consumer takes the result.
- ready  out  1  block is idle and can accept start.
- busy  out  1  calculation in progress.
- valid  out  1  result available; held until ack.
- result  out  2·WIDTH  {HI,LO} result.

## Operation
- Signed ops (MULT, MADD, MSUB): a and b are sign-extended to E = WIDTH+2 bits. Unsigned ops: zero-extended. N = E/2 Booth groups (17 for WIDTH=32).
- Subtract ops: the multiplicand is negated once at load, using E-bit arithmetic, so no overflow occurs at −2^(WIDTH−1). The result is acc − a·b = acc + (−a)·b.
- Booth group i = {b_ext[2i+1], b_ext[2i], b_ext[2i−1]}, with b_ext[−1]=0. Selects 0, ±X, ±2X. The term is sign-extended to 2·WIDTH+4 bits and shifted left by 2i.
- The accumulator is 2·WIDTH+4 bits wide. At load it holds acc_in for accumulate ops and 0 for MULT/MULTU. result = accumulator[2·WIDTH−1:0], which wraps modulo 2^(2·WIDTH) as the ISA specifies.
- FSM states:
  - IDLE: ready=1. On start & !flush: load operands, clear the step counter, go to CALC.
  - CALC: busy=1. Each cycle adds PP_PER_CYCLE groups and advances the counter. After the last group (S = ceil(N/PP_PER_CYCLE) cycles), go to DONE. Any surplus group in the final cycle contributes 0.
  - DONE: valid=1 and result is stable. On ack, go to IDLE.
- flush in CALC or DONE: go to IDLE on the next edge, no valid is produced, and result is undefined. flush in IDLE: no effect. flush together with start: flush wins and start is dropped.
- start while ready=0 is ignored. The outstanding request is not corrupted.
- ack outside DONE is ignored.

## Timing
- Reset (asynchronous assert, synchronous deassert at system level) gives: state IDLE, ready=1, busy=0, valid=0, result=0, counter=0. Reset during CALC or DONE aborts immediately.
- Latency: valid rises S edges after the edge that accepts start. For WIDTH=32 that is 17 (PP_PER_CYCLE=1) or 9 (PP_PER_CYCLE=2).
- ack in DONE drops valid on the next edge, and ready rises on that same edge. A new start is accepted one cycle later at the earliest.
- The op, a, b and acc_in inputs may change freely after the accept edge.

## Structure
- Package booth_pkg holds the op encoding constants, the state enum {IDLE, CALC, DONE}, and helpers: is_signed(op), is_accum(op), is_sub(op).
- Sub-module booth_pp_sel is a combinational, parametrised radix-4 selector. Inputs: E-bit X, 3-bit group. Output: the E+1-bit signed partial product. It is instanced PP_PER_CYCLE times.
- Top module: FSM, step counter, shift registers for the multiplier and multiplicand, accumulator adder.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 → result 0xFFFFFFFF_FFFFFFFE; valid rises exactly 17 cycles after start (PP_PER_CYCLE=1) and 9 cycles after (PP_PER_CYCLE=2).
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE_00000001. MULT a=0x80000000, b=0x80000000 → 0x40000000_00000000.
- MADD acc_in=0x10, a=3, b=5 → 0x1F. MSUB acc_in=0x10, a=3, b=5 → 0x1. MSUBU acc_in=0, a=0x80000000, b=2 → 0xFFFFFFFF_00000000.
- flush asserted at CALC cycle 5 → busy=0 and ready=1 on the next edge, valid never asserted. start with flush in IDLE → stays IDLE.
- valid held for 10 cycles without ack → result stable. A start pulse during that time is ignored. After ack, ready=1 on the next edge.
- resetn pulled low mid-CALC → all outputs at reset values immediately. A subsequent MULT 7×(−3) returns 0xFFFFFFFF_FFFFFFEB.
